// File: rtl/if_prefetch_stage.sv
// Fetch stage with a DEPTH-entry prefetch queue and credit-based request issue.
// Decouples PC generation from a variable-latency, in-order instruction memory.
module if_prefetch_stage #(
    parameter int ADDR_W   = 32,
    parameter int INSTR_W  = 32,
    parameter int DEPTH    = 4,
    parameter int MAX_OUT  = 2,
    parameter int RESET_PC = 0,
    parameter int PC_STEP  = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               branchTaken,
    input  logic [ADDR_W-1:0]  branchAddress,
    output logic               mem_req_valid,
    input  logic               mem_req_ready,
    output logic [ADDR_W-1:0]  mem_req_addr,
    input  logic               mem_resp_valid,
    input  logic [INSTR_W-1:0] mem_resp_data,
    output logic [ADDR_W-1:0]  PCR,
    output logic [INSTR_W-1:0] instructionR,
    output logic               validR
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OUT_W = $clog2(MAX_OUT + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int SUM_W = CNT_W + OUT_W;

    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  resp_pc;
    logic [CNT_W-1:0]   count;
    logic [OUT_W-1:0]   outstanding;
    logic [OUT_W-1:0]   drop_cnt;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]  q_pc    [DEPTH];
    logic [INSTR_W-1:0] q_instr [DEPTH];

    logic             fire;
    logic             resp_ok;
    logic             drop;
    logic             enq;
    logic             pop;
    logic [SUM_W-1:0] committed;

    // Credits count queued entries plus live (non-stale) requests, so every
    // accepted response is guaranteed a free slot.
    always_comb begin
        committed     = SUM_W'(count) + SUM_W'(outstanding - drop_cnt);
        mem_req_valid = rst && !branchTaken
                        && (committed < SUM_W'(DEPTH))
                        && (outstanding < OUT_W'(MAX_OUT));
        mem_req_addr  = fetch_pc;
        fire          = mem_req_valid && mem_req_ready;
        resp_ok       = mem_resp_valid && (outstanding != '0);
        drop          = resp_ok && ((drop_cnt != '0) || branchTaken);
        enq           = resp_ok && !drop;
        pop           = !branchTaken && !freeze && (count != '0);
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_pc[wr_ptr]    <= resp_pc + ADDR_W'(PC_STEP);
            q_instr[wr_ptr] <= mem_resp_data;
        end
    end

    // Control state and output register; a redirect overrides everything else.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc     <= ADDR_W'(RESET_PC);
            resp_pc      <= ADDR_W'(RESET_PC);
            count        <= '0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            PCR          <= '0;
            instructionR <= '0;
            validR       <= 1'b0;
        end else begin
            case ({fire, resp_ok})
                2'b10:   outstanding <= outstanding + OUT_W'(1);
                2'b01:   outstanding <= outstanding - OUT_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (branchTaken) begin
                fetch_pc     <= branchAddress;
                resp_pc      <= branchAddress;
                count        <= '0;
                wr_ptr       <= '0;
                rd_ptr       <= '0;
                drop_cnt     <= resp_ok ? outstanding - OUT_W'(1) : outstanding;
                PCR          <= '0;
                instructionR <= '0;
                validR       <= 1'b0;
            end else begin
                if (fire) begin
                    fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
                end
                if (enq) begin
                    resp_pc <= resp_pc + ADDR_W'(PC_STEP);
                    wr_ptr  <= wr_ptr + PTR_W'(1);
                end
                if (drop && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - OUT_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
                case ({enq, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
                // The head is read before this cycle's enqueue lands, so a
                // response never bypasses straight into the output register.
                if (!freeze) begin
                    if (count != '0) begin
                        PCR          <= q_pc[rd_ptr];
                        instructionR <= q_instr[rd_ptr];
                        validR       <= 1'b1;
                    end else begin
                        validR <= 1'b0;
                    end
                end
            end
        end
    end

endmodule
